// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------------------
// turn_sequencer
//
// Sits directly behind the path planner. The planner streams one 2-bit turn
// command per arena node into an internal FIFO (00 straight, 01 left,
// 10 right, 11 backward). After a start pulse the block line-follows and, at
// every junction reported by the line-sensor front end, pops one command and
// plays it out as a timed open-loop manoeuvre. A junction that arrives with
// the queue empty ends the run (DONE).
//
// Ports
//   clk_50      in   system clock, rising edge
//   reset       in   synchronous, active-high
//   cmd_valid   in   planner presents a command
//   cmd_data    in   [1:0] command code
//   cmd_last    in   final command of the path (closes the FIFO)
//   cmd_ready   out  write accepted when cmd_valid && cmd_ready
//   start       in   one-cycle pulse: begin run (IDLE) / clear path (DONE)
//   node_detect in   level, high while the robot is over a junction
//   motion      out  [2:0] 000 stop, 001 follow, 010 pivot L, 011 pivot R,
//                   100 forward blind
//   busy        out  high in FOLLOW or EXEC
//   done        out  high in DONE
//   cmd_count   out  [5:0] entries currently queued
//   node_index  out  [5:0] commands executed since start
//   error       out  sticky: write attempted while the FIFO was full
// ---------------------------------------------------------------------------
module turn_sequencer #(
    parameter int DEPTH        = 37,
    parameter int TURN_CYCLES  = 25000000,
    parameter int CROSS_CYCLES = 5000000,
    parameter int CNT_W        = 32
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_data,
    input  logic       cmd_last,
    output logic       cmd_ready,
    input  logic       start,
    input  logic       node_detect,
    output logic [2:0] motion,
    output logic       busy,
    output logic       done,
    output logic [5:0] cmd_count,
    output logic [5:0] node_index,
    output logic       error
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [5:0]       DEPTH_C  = 6'(DEPTH);

    localparam logic [CNT_W-1:0] T_CROSS = CNT_W'(CROSS_CYCLES);
    localparam logic [CNT_W-1:0] T_TURN  = CNT_W'(TURN_CYCLES);
    localparam logic [CNT_W-1:0] T_UTURN = CNT_W'(2 * TURN_CYCLES);

    localparam logic [2:0] MOT_STOP   = 3'b000;
    localparam logic [2:0] MOT_FOLLOW = 3'b001;
    localparam logic [2:0] MOT_LEFT   = 3'b010;
    localparam logic [2:0] MOT_RIGHT  = 3'b011;
    localparam logic [2:0] MOT_FWD    = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FOLLOW = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [5:0]       r_count;
    logic             r_loaded;
    logic             r_node_q;
    logic [CNT_W-1:0] r_timer;
    logic [5:0]       r_node_idx;
    logic             r_error;
    logic [2:0]       r_exec_motion;

    logic             w_node_rise;
    logic             w_ready;
    logic             w_wr;
    logic             w_overflow;
    logic             w_path_ready;
    logic             w_start_run;
    logic             w_pop;
    logic             w_clear;
    logic [2:0]       w_motion;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_load_val;
    logic [2:0]       w_load_motion;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    // Only a fresh rising edge counts as a junction; a level still high when
    // a manoeuvre ends must not trigger a second pop.
    assign w_node_rise = node_detect && !r_node_q;

    assign w_ready    = (r_state == S_IDLE) && !r_loaded && (r_count < DEPTH_C);
    assign w_wr       = cmd_valid && w_ready;
    assign w_overflow = (r_state == S_IDLE) && cmd_valid && !r_loaded &&
                        (r_count == DEPTH_C);

    // A completely full FIFO is treated as a finished path even if the
    // planner never flagged cmd_last: no further command could be accepted.
    assign w_path_ready = r_loaded || (r_count == DEPTH_C);

    // DEPTH need not be a power of two, so wrap explicitly.
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    // Manoeuvre decode for the command at the head of the queue.
    always_comb begin
        w_load_val    = T_UTURN;
        w_load_motion = MOT_RIGHT;
        case (r_mem[r_rd_ptr])
            2'b00: begin
                w_load_val    = T_CROSS;
                w_load_motion = MOT_FWD;
            end
            2'b01: begin
                w_load_val    = T_TURN;
                w_load_motion = MOT_LEFT;
            end
            2'b10: begin
                w_load_val    = T_TURN;
                w_load_motion = MOT_RIGHT;
            end
            default: begin
                // Backward: 180-degree pivot to the right.
                w_load_val    = T_UTURN;
                w_load_motion = MOT_RIGHT;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_motion    = MOT_STOP;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_start_run = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Uses the registered loaded/count, so a write in the same
                // cycle as start does not make start take effect.
                if (start && w_path_ready && (r_count != 6'd0)) begin
                    w_state_nxt = S_FOLLOW;
                    w_start_run = 1'b1;
                end
            end
            S_FOLLOW: begin
                w_motion = MOT_FOLLOW;
                w_busy   = 1'b1;
                if (w_node_rise) begin
                    if (r_count == 6'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                w_motion = r_exec_motion;
                w_busy   = 1'b1;
                // Timer holds the remaining cycles including this one.
                if (r_timer == CNT_W'(1)) begin
                    w_state_nxt = S_FOLLOW;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_state_nxt = S_IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_node_q   <= 1'b0;
            r_loaded   <= 1'b0;
            r_count    <= 6'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_timer    <= '0;
            r_node_idx <= 6'd0;
            r_error    <= 1'b0;
        end else begin
            r_node_q <= node_detect;

            if (w_clear) begin
                r_loaded <= 1'b0;
                r_count  <= 6'd0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else if (w_wr) begin
                r_wr_ptr <= w_wr_ptr_nxt;
                r_count  <= r_count + 6'd1;
                if (cmd_last) begin
                    r_loaded <= 1'b1;
                end
            end else if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
                r_count  <= r_count - 6'd1;
            end

            if (w_overflow) begin
                r_error <= 1'b1;
            end

            if (w_start_run) begin
                r_node_idx <= 6'd0;
            end else if (w_pop) begin
                r_node_idx <= r_node_idx + 6'd1;
            end

            if (w_pop) begin
                r_timer <= w_load_val;
            end else if (r_state == S_EXEC) begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    // Command storage and the active manoeuvre code carry no reset.
    always_ff @(posedge clk_50) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= cmd_data;
        end
        if (w_pop) begin
            r_exec_motion <= w_load_motion;
        end
    end

    assign cmd_ready  = w_ready;
    assign motion     = w_motion;
    assign busy       = w_busy;
    assign done       = w_done;
    assign cmd_count  = r_count;
    assign node_index = r_node_idx;
    assign error      = r_error;

endmodule
